// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM pin-level responder.
package sram_pkg;

    localparam int          DATA_W         = 16;
    localparam int          PIN_AW         = 20;
    localparam logic [15:0] RANGE_ERR_DATA = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_READ_WAIT    = 2'd1,
        ST_READ_DRIVE   = 2'd2,
        ST_WRITE_ACTIVE = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Internal storage port between the responder FSM (master) and its memory array (slave).
interface sram_responder_if #(
    parameter int AW = 10
);
    import sram_pkg::*;

    // we and re are single-cycle strobes with no back-pressure; rdata is valid
    // from the cycle after re until the next re.
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, be, we, re, input rdata);
    modport slave  (input addr, wdata, be, we, re, output rdata);

endinterface

// File: rtl/sram_responder_mem.sv
// Synchronous single-port storage with per-byte write enable and one-cycle read.
module sram_resp_mem
    import sram_pkg::*;
#(
    parameter int AW = 10
) (
    input logic               clk,
    sram_responder_if.slave   bus
);

    logic [7:0] mem_lo [2**AW];
    logic [7:0] mem_hi [2**AW];

    always_ff @(posedge clk) begin
        if (bus.we && bus.be[0]) mem_lo[bus.addr] <= bus.wdata[7:0];
        if (bus.we && bus.be[1]) mem_hi[bus.addr] <= bus.wdata[DATA_W-1:8];
        if (bus.re)              bus.rdata <= {mem_hi[bus.addr], mem_lo[bus.addr]};
    end

endmodule

// File: rtl/sram_responder.sv
// Behaves like an asynchronous SRAM seen from its pins: registered pin sampling,
// a read/write FSM, programmable read latency, access counters and sticky error flags.
module sram_responder
    import sram_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    inout  wire  [15:0] sram_DQ,
    input  logic [19:0] sram_ADDR,
    input  logic        sram_LB_N,
    input  logic        sram_UB_N,
    input  logic        sram_CE_N,
    input  logic        sram_OE_N,
    input  logic        sram_WE_N,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        err_contention,
    output logic        err_range,
    output state_t      dbg_state
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 2);

    logic [PIN_AW-1:0] addr_q;
    logic [DATA_W-1:0] dq_q;
    logic              lb_n_q, ub_n_q, ce_n_q, oe_n_q, we_n_q;

    state_t            state;
    logic [2:0]        lat_cnt;
    logic [PIN_AW-1:0] rd_addr, w_addr;
    logic              rd_oor;
    logic [DATA_W-1:0] w_data;
    logic              w_lb_n, w_ub_n;

    sram_responder_if #(.AW(MEM_AW)) mem_bus ();

    sram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk (clk_clk),
        .bus (mem_bus.slave)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_q <= '0;
            dq_q   <= '0;
            lb_n_q <= 1'b1;
            ub_n_q <= 1'b1;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
        end else begin
            addr_q <= sram_ADDR;
            dq_q   <= sram_DQ;
            lb_n_q <= sram_LB_N;
            ub_n_q <= sram_UB_N;
            ce_n_q <= sram_CE_N;
            oe_n_q <= sram_OE_N;
            we_n_q <= sram_WE_N;
        end
    end

    // WE dominates OE, so a read request needs WE_N high.
    logic write_req, read_req, contention, addr_oor, w_oor, addr_moved;
    assign write_req  = !ce_n_q && !we_n_q;
    assign read_req   = !ce_n_q && we_n_q && !oe_n_q;
    assign contention = !ce_n_q && !we_n_q && !oe_n_q;
    assign addr_oor   = |addr_q[PIN_AW-1:MEM_AW];
    assign w_oor      = |w_addr[PIN_AW-1:MEM_AW];
    assign addr_moved = addr_q != rd_addr;

    always_comb begin
        mem_bus.addr  = addr_q[MEM_AW-1:0];
        mem_bus.wdata = w_data;
        mem_bus.be    = ~{w_ub_n, w_lb_n};
        mem_bus.we    = 1'b0;
        mem_bus.re    = 1'b0;
        case (state)
            ST_IDLE:       mem_bus.re = !write_req && read_req;
            ST_READ_DRIVE: mem_bus.re = read_req && addr_moved;
            ST_WRITE_ACTIVE: begin
                if (!write_req) begin
                    mem_bus.we   = !w_oor;
                    mem_bus.addr = w_addr[MEM_AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= ST_IDLE;
            lat_cnt        <= '0;
            rd_addr        <= '0;
            rd_oor         <= 1'b0;
            w_addr         <= '0;
            w_data         <= '0;
            w_lb_n         <= 1'b1;
            w_ub_n         <= 1'b1;
            rd_count       <= '0;
            wr_count       <= '0;
            err_contention <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            if (contention) err_contention <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (write_req) begin
                        state  <= ST_WRITE_ACTIVE;
                        w_addr <= addr_q;
                        w_data <= dq_q;
                        w_lb_n <= lb_n_q;
                        w_ub_n <= ub_n_q;
                    end else if (read_req) begin
                        state   <= ST_READ_WAIT;
                        lat_cnt <= '0;
                        rd_addr <= addr_q;
                        rd_oor  <= addr_oor;
                        if (addr_oor) err_range <= 1'b1;
                    end
                end
                ST_READ_WAIT: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        state    <= ST_READ_DRIVE;
                        rd_count <= sat_inc(rd_count);
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ST_READ_DRIVE: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (addr_moved) begin
                        state   <= ST_READ_WAIT;
                        lat_cnt <= '0;
                        rd_addr <= addr_q;
                        rd_oor  <= addr_oor;
                        if (addr_oor) err_range <= 1'b1;
                    end
                end
                ST_WRITE_ACTIVE: begin
                    if (write_req) begin
                        w_addr <= addr_q;
                        w_data <= dq_q;
                        w_lb_n <= lb_n_q;
                        w_ub_n <= ub_n_q;
                    end else begin
                        state    <= ST_IDLE;
                        wr_count <= sat_inc(wr_count);
                        if (w_oor) err_range <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    // Enable uses the raw pins so the bus is released without waiting for an edge.
    logic              drive_ok;
    logic [DATA_W-1:0] dq_out;
    assign drive_ok = (state == ST_READ_DRIVE) && !sram_CE_N && !sram_OE_N && sram_WE_N;
    assign dq_out   = rd_oor ? RANGE_ERR_DATA : mem_bus.rdata;
    assign sram_DQ  = {(drive_ok && !sram_UB_N) ? dq_out[15:8] : 8'hzz,
                       (drive_ok && !sram_LB_N) ? dq_out[7:0]  : 8'hzz};

endmodule
